// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared RV32M funct3 codes, FSM states and divide constants
package muldiv_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } muldiv_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_DONE = 2'd2
  } muldiv_state_t;

  localparam logic [XLEN-1:0] DIV_ZERO_QUOTIENT = '1;
  localparam logic [XLEN-1:0] OVERFLOW_DIVIDEND = {1'b1, {(XLEN-1){1'b0}}};

endpackage

// File: rtl/muldiv_negate.sv
// rtl/muldiv_negate.sv - conditional two's complement used for operand and result sign fix-up
module muldiv_negate #(
  parameter int Width = 32
) (
  input  logic             neg,
  input  logic [Width-1:0] value,
  output logic [Width-1:0] result
);

  assign result = neg ? (~value + {{(Width-1){1'b0}}, 1'b1}) : value;

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide unit, one result bit per clock
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int AddressBitWidth = 5,
  parameter int Width           = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [2:0]                 op,
  input  logic [Width-1:0]           rs1_data,
  input  logic [Width-1:0]           rs2_data,
  input  logic [AddressBitWidth-1:0] rd_in,
  output logic                       ready,
  output logic [AddressBitWidth-1:0] rd,
  output logic                       rd_write_enable,
  output logic [Width-1:0]           rd_data_out
);

  localparam int CntW = $clog2(Width);
  localparam logic [CntW-1:0] LastCnt = CntW'(Width - 1);
  localparam logic [Width-1:0] DivzQuotient = {Width{DIV_ZERO_QUOTIENT[0]}};
  localparam logic [Width-1:0] OvfDividend  = {OVERFLOW_DIVIDEND[XLEN-1], {(Width-1){1'b0}}};

  muldiv_state_t              state_q, state_d;
  muldiv_op_t                 op_q;
  logic [CntW-1:0]            cnt_q;
  logic [Width-1:0]           hi_q, lo_q, opnd_q, result_q;
  logic                       neg_q;
  logic [AddressBitWidth-1:0] rd_q;

  muldiv_op_t       op_in;
  logic             a_neg, b_neg, div_zero, div_ovf, fast;
  logic [Width-1:0] mag_a, mag_b, fast_result;

  assign op_in    = muldiv_op_t'(op);
  assign a_neg    = (op_in inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM}) && rs1_data[Width-1];
  assign b_neg    = (op_in inside {OP_MULH, OP_DIV, OP_REM}) && rs2_data[Width-1];
  assign div_zero = op[2] && (rs2_data == '0);
  assign div_ovf  = (op_in inside {OP_DIV, OP_REM}) && (rs1_data == OvfDividend) && (rs2_data == '1);
  assign fast     = div_zero || div_ovf;
  // op[1] distinguishes REM/REMU from DIV/DIVU among the divide codes
  assign fast_result = div_zero ? (op[1] ? rs1_data : DivzQuotient) : (op[1] ? '0 : OvfDividend);

  muldiv_negate #(.Width(Width)) u_mag_a (.neg(a_neg), .value(rs1_data), .result(mag_a));
  muldiv_negate #(.Width(Width)) u_mag_b (.neg(b_neg), .value(rs2_data), .result(mag_b));

  // hi/lo form one shift register: {accumulator, multiplier} or {remainder, dividend/quotient}
  logic [Width:0]   mul_sum, div_shift, div_diff;
  logic [Width-1:0] step_hi, step_lo;

  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    div_shift = {hi_q, lo_q[Width-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
    if (op_q[2]) begin
      step_hi = div_diff[Width] ? div_shift[Width-1:0] : div_diff[Width-1:0];
      step_lo = {lo_q[Width-2:0], ~div_diff[Width]};
    end else begin
      step_hi = mul_sum[Width:1];
      step_lo = {mul_sum[0], lo_q[Width-1:1]};
    end
  end

  logic [2*Width-1:0] prod_fix;
  logic [Width-1:0]   div_fix, final_result;

  muldiv_negate #(.Width(2*Width)) u_neg_prod (
    .neg(neg_q), .value({step_hi, step_lo}), .result(prod_fix));
  muldiv_negate #(.Width(Width)) u_neg_div (
    .neg(neg_q), .value(op_q[1] ? step_hi : step_lo), .result(div_fix));

  assign final_result = op_q[2] ? div_fix :
                        (op_q == OP_MUL) ? prod_fix[Width-1:0] : prod_fix[2*Width-1:Width];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = fast ? ST_DONE : ST_ITER;
      ST_ITER: if (cnt_q == LastCnt) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= OP_MUL;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      opnd_q   <= '0;
      result_q <= '0;
      neg_q    <= 1'b0;
      rd_q     <= '0;
    end else if (state_q == ST_IDLE) begin
      if (start) begin
        op_q   <= op_in;
        rd_q   <= rd_in;
        cnt_q  <= '0;
        hi_q   <= '0;
        neg_q  <= (op_in inside {OP_REM, OP_REMU}) ? a_neg : (a_neg ^ b_neg);
        opnd_q <= op[2] ? mag_b : mag_a;
        lo_q   <= op[2] ? mag_a : mag_b;
        if (fast) result_q <= fast_result;
      end
    end else if (state_q == ST_ITER) begin
      hi_q  <= step_hi;
      lo_q  <= step_lo;
      cnt_q <= cnt_q + CntW'(1);
      if (cnt_q == LastCnt) result_q <= final_result;
    end
  end

  assign ready           = (state_q == ST_IDLE);
  assign rd              = rd_q;
  assign rd_write_enable = (state_q == ST_DONE) && (rd_q != '0);
  assign rd_data_out     = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed and randomized RV32M checks against an arithmetic reference model
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = '0;
  logic [31:0] rs1_data = '0;
  logic [31:0] rs2_data = '0;
  logic [4:0]  rd_in = '0;
  logic        ready;
  logic [4:0]  rd;
  logic        rd_write_enable;
  logic [31:0] rd_data_out;

  int n_checks = 0;
  int n_fail   = 0;

  muldiv_unit #(.AddressBitWidth(5), .Width(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .rd_in(rd_in),
    .ready(ready), .rd(rd), .rd_write_enable(rd_write_enable), .rd_data_out(rd_data_out)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_result(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    int sa, sb;
    sa = a;
    sb = b;
    case (o)
      3'd0: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; return p[31:0]; end
      3'd1: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; return p[63:32]; end
      3'd2: begin p = {{32{a[31]}}, a} * {32'd0, b};       return p[63:32]; end
      3'd3: begin p = {32'd0, a} * {32'd0, b};             return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'(sa / sb);
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return 32'(sa % sb);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_fast(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    if (o < 3'd4) return 1'b0;
    if (b == 0) return 1'b1;
    return (o == 3'd4 || o == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one op at a negedge, accept on the next posedge, then watch every
  // following negedge until ready returns; k counts edges after the accepting edge.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] r, input bit poke);
    logic [31:0] exp_data, got_data;
    logic [4:0]  got_rd;
    int lat, pulses, pulse_k, ready_k;
    exp_data = ref_result(o, a, b);
    lat = is_fast(o, a, b) ? 0 : 32;
    check("ready_before_start", 32'(ready), 32'd1);
    op = o; rs1_data = a; rs2_data = b; rd_in = r; start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0; op = 3'($urandom); rs1_data = $urandom; rs2_data = $urandom; rd_in = 5'($urandom);
    pulses = 0; pulse_k = -1; ready_k = -1; got_data = 'x; got_rd = 'x;
    for (int k = 0; k < 64; k++) begin
      start = (poke && k == 5);
      if (rd_write_enable) begin
        pulses++;
        if (pulse_k < 0) begin pulse_k = k; got_data = rd_data_out; got_rd = rd; end
      end
      if (ready) begin ready_k = k; break; end
      @(posedge clk); @(negedge clk);
    end
    start = 1'b0;
    check($sformatf("pulses op%0d a=%h b=%h rd=%0d", o, a, b, r), 32'(pulses), (r != 0) ? 32'd1 : 32'd0);
    if (r != 0) begin
      check($sformatf("latency op%0d a=%h b=%h", o, a, b), 32'(pulse_k), 32'(lat));
      check($sformatf("data op%0d a=%h b=%h", o, a, b), got_data, exp_data);
      check($sformatf("rd op%0d", o), 32'(got_rd), 32'(r));
    end
    check($sformatf("ready_return op%0d a=%h b=%h", o, a, b), 32'(ready_k), 32'(lat + 1));
    check("rd_held", 32'(rd), 32'(r));
  endtask

  task automatic reset_mid_op();
    int pulses;
    op = 3'd0; rs1_data = 32'd12345; rs2_data = 32'd678; rd_in = 5'd9; start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 10; k++) begin @(posedge clk); @(negedge clk); end
    rst_n = 1'b0;
    #1;
    check("rst_mid ready", 32'(ready), 32'd1);
    check("rst_mid we", 32'(rd_write_enable), 32'd0);
    check("rst_mid rd", 32'(rd), 32'd0);
    check("rst_mid data", rd_data_out, 32'd0);
    pulses = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (rd_write_enable) pulses++;
    end
    rst_n = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); @(negedge clk);
      if (rd_write_enable) pulses++;
    end
    check("rst_mid no_pulse", 32'(pulses), 32'd0);
  endtask

  initial begin
    #1;
    check("reset ready", 32'(ready), 32'd1);
    check("reset we", 32'(rd_write_enable), 32'd0);
    check("reset rd", 32'(rd), 32'd0);
    check("reset data", rd_data_out, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 1'b0);
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd1, 1'b0);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 1'b0);
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 1'b0);
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd4, 1'b0);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd6, 1'b0);
    run_op(3'd5, 32'd100, 32'd7, 5'd7, 1'b0);
    run_op(3'd7, 32'd100, 32'd7, 5'd8, 1'b0);
    run_op(3'd5, 32'd5, 32'd0, 5'd10, 1'b0);
    run_op(3'd6, 32'd5, 32'd0, 5'd11, 1'b0);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 1'b0);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 1'b0);
    run_op(3'd0, 32'd1000, 32'd3000, 5'd14, 1'b1);
    run_op(3'd4, 32'd50, 32'd5, 5'd0, 1'b0);

    reset_mid_op();
    run_op(3'd0, 32'hDEAD_BEEF, 32'd3, 5'd15, 1'b0);

    for (int i = 0; i < 30; i++) begin
      logic [31:0] a, b;
      a = pick_operand();
      b = pick_operand();
      run_op(3'($urandom), a, b, 5'($urandom), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
